// File: rtl/apb_arb_pkg.sv
// Shared widths, FSM state type and request payload for the two-requester APB master arbiter.
package apb_arb_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int NREQ   = 2;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } apb_req_t;

    function automatic logic [NREQ-1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/apb_master_arb_if.sv
// Requester-side handshake plus APB bus signals; master = arbiter view, slave = environment view.
interface apb_master_arb_if;
    import apb_arb_pkg::*;

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_write;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]      rsp_rdata;
    logic                   rsp_err;
    logic                   busy;

    logic                   psel;
    logic                   penable;
    logic                   pwrite;
    logic [ADDR_W-1:0]      paddr;
    logic [DATA_W-1:0]      pwdata;
    logic [DATA_W-1:0]      prdata;
    logic                   pready;
    logic                   pslverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  prdata, pready, pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output prdata, pready, pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        input  psel, penable, pwrite, paddr, pwdata
    );

endinterface

// File: rtl/apb_rr_arb.sv
// Two-way round-robin grant; the last_grant register only moves when the owner accepts a request.
module apb_rr_arb
    import apb_arb_pkg::*;
(
    input  logic            pclkg,
    input  logic            presetn,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_en,
    output logic [NREQ-1:0] o_grant,
    output logic            o_grant_idx
);

    logic r_last;
    logic w_idx;

    // On a tie the requester that did not win last time takes the bus.
    assign w_idx = (i_req == 2'b10) ? 1'b1 :
                   (i_req == 2'b11) ? ~r_last : 1'b0;

    assign o_grant     = (i_req == '0) ? '0 : idx_to_onehot(w_idx);
    assign o_grant_idx = w_idx;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge pclkg or negedge presetn) begin
        if (!presetn) begin
            r_last <= 1'b1;
        end else if (i_en && (i_req != '0)) begin
            r_last <= w_idx;
        end
    end

endmodule

// File: rtl/apb_master_arb.sv
// APB master shared by two requesters: arbitrate in IDLE, run SETUP/ACCESS, report in RESP.
module apb_master_arb
    import apb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic             pclkg,
    input  logic             presetn,
    apb_master_arb_if.master io_bus
);

    apb_state_e        r_state;
    apb_state_e        w_state_nxt;
    apb_req_t          r_req;
    apb_req_t          w_sel_req;
    logic              r_owner;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic              w_accept;
    logic              w_done;
    logic              w_abort;
    logic              w_on_bus;
    logic [NREQ-1:0]   w_grant;
    logic              w_gidx;

    apb_rr_arb u_arb (
        .pclkg       (pclkg),
        .presetn     (presetn),
        .i_req       (io_bus.req_valid),
        .i_en        (w_accept),
        .o_grant     (w_grant),
        .o_grant_idx (w_gidx)
    );

    always_comb begin
        w_sel_req.write = io_bus.req_write[w_gidx];
        w_sel_req.addr  = w_gidx ? io_bus.req_addr[ADDR_W +: ADDR_W]  : io_bus.req_addr[0 +: ADDR_W];
        w_sel_req.wdata = w_gidx ? io_bus.req_wdata[DATA_W +: DATA_W] : io_bus.req_wdata[0 +: DATA_W];
    end

    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (io_bus.req_valid != '0) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: w_state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                // pready wins over a timeout landing in the same cycle.
                if (io_bus.pready) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if (w_cnt_inc == CNT_W'(TIMEOUT_CYC)) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclkg or negedge presetn) begin
        if (!presetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: payload registers are reset too, so nothing stale can reach the bus after reset.
    always_ff @(posedge pclkg or negedge presetn) begin
        if (!presetn) begin
            r_req   <= '0;
            r_owner <= 1'b0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_req   <= w_sel_req;
                r_owner <= w_gidx;
            end
            if (r_state == ST_SETUP) begin
                r_cnt <= '0;
            end else if ((r_state == ST_ACCESS) && !io_bus.pready) begin
                r_cnt <= w_cnt_inc;
            end
            if (w_done) begin
                r_rdata <= r_req.write ? '0 : io_bus.prdata;
                r_err   <= io_bus.pslverr;
            end else if (w_abort) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end
        end
    end

    assign w_on_bus = (r_state == ST_SETUP) || (r_state == ST_ACCESS);

    assign io_bus.psel      = w_on_bus;
    assign io_bus.penable   = (r_state == ST_ACCESS);
    assign io_bus.pwrite    = w_on_bus && r_req.write;
    assign io_bus.paddr     = w_on_bus ? r_req.addr  : '0;
    assign io_bus.pwdata    = w_on_bus ? r_req.wdata : '0;
    // Gated by presetn so a pending request cannot show an accept while reset is held.
    assign io_bus.req_ready = (w_accept && presetn) ? w_grant : '0;
    assign io_bus.rsp_valid = (r_state == ST_RESP) ? idx_to_onehot(r_owner) : '0;
    assign io_bus.rsp_rdata = (r_state == ST_RESP) ? r_rdata : '0;
    assign io_bus.rsp_err   = (r_state == ST_RESP) && r_err;
    assign io_bus.busy      = (r_state != ST_IDLE);

endmodule
